sdram_init_sequencer: RTL and testbench
=======================================

# sdram_init_sequencer

Consumes the active-low power-up hold (`sdram_init_n`) produced by the startup-delay unit and drives the JEDEC SDRAM initialisation command sequence: PRECHARGE ALL, N × AUTO REFRESH, LOAD MODE REGISTER. It then asserts `init_done`, which hands the bus to the Apple IIe SDRAM controller and tester. It sits between the startup-delay unit and the SDRAM command/address pins, on the 111.857 MHz SDRAM clock.

## Interface
- `CLK`, default 111857000.0: clock frequency in Hz, used for ns→cycle conversion.
- `T_RP_NS`, default 20: precharge period (ns).
- `T_RFC_NS`, default 70: refresh cycle time (ns).
- `T_MRD_CYC`, default 2: mode-register set time (cycles).
- `REFRESH_COUNT`, default 8: number of AUTO REFRESH commands (valid range 2..15).
- `ADDR_BITS`, default 13: SDRAM address width.
- `MODE_REG`, default 13'h020: mode word (CAS latency 2, burst length 1, sequential).
- `clk14M`  input  1  sole clock, rising edge; all logic in this domain.
- `reset`  input  1  synchronous, active-high.
- `sdram_init_n`  input  1  low = power-up wait in progress; the low→high edge starts the sequence.
- `sdram_cke`  output  1  clock enable.
- `sdram_cmd`  output  4  {cs_n, ras_n, cas_n, we_n}.
- `sdram_addr`  output  ADDR_BITS  address bus.
- `sdram_ba`  output  2  bank address.
- `init_busy`  output  1  high from PRECHARGE issue until `init_done` rises.
- `init_done`  output  1  sequence complete; controller may issue commands.

## Operation
- Command encodings: INHIBIT 4'b1111, NOP 4'b0111, PRECHARGE 4'b0010, AUTO REFRESH 4'b0001, LOAD MODE 4'b0000.
- Cycle constants: T_RP = ceil(T_RP_NS·CLK/1e9), T_RFC = ceil(T_RFC_NS·CLK/1e9). At defaults, T_RP = 3 and T_RFC = 8.
- States:
  - IDLE: cmd INHIBIT, cke 0. Moves to HOLD when `sdram_init_n` = 0.
  - HOLD: cke 1, cmd NOP. Moves to PRECHARGE on a low→high edge of `sdram_init_n` (current sample 1, registered previous sample 0).
  - PRECHARGE: cmd PRECHARGE, addr[10] = 1 (all banks), other addr bits 0. Moves to WAIT_RP.
  - WAIT_RP: NOP. Moves to REFRESH.
  - REFRESH: cmd AUTO REFRESH. Increments the refresh counter. Moves to WAIT_RFC.
  - WAIT_RFC: NOP. Returns to REFRESH while count < REFRESH_COUNT, else moves to LOAD_MODE.
  - LOAD_MODE: cmd LOAD MODE, addr = MODE_REG, ba = 0. Moves to WAIT_MRD.
  - WAIT_MRD: NOP. Moves to DONE.
  - DONE: `init_done` = 1; cmd/addr/ba outputs are released at NOP/0.
- Wait states: every command occupies exactly one cycle. Its wait state lasts (T−1) cycles, so consecutive commands are spaced exactly T cycles apart.
- Abort: `sdram_init_n` = 0 in any state other than IDLE/HOLD forces HOLD on the next edge. This clears `init_done`, `init_busy`, the refresh counter and the wait counter. A later rising edge restarts the full sequence from PRECHARGE.
- A rising edge in IDLE (no prior low seen after reset) is ignored. The sequence only arms after a low sample.
- A sequence only re-runs through the abort path. DONE otherwise holds indefinitely.

## Timing
- All outputs are registered.
- Reset values: cke 0, cmd 4'b1111, addr 0, ba 0, init_busy 0, init_done 0, state IDLE, counters 0.
- Start latency: edge sampled at cycle E, so PRECHARGE appears on `sdram_cmd` at E+1 and `init_busy` rises at E+1.
- Defaults, with P = the PRECHARGE cycle:
  - Refreshes at P+3, P+11, …, P+59.
  - LOAD MODE at P+67.
  - `init_done` = 1 and `init_busy` = 0 from P+69.
- General completion cycle: P + T_RP + REFRESH_COUNT·T_RFC + T_MRD_CYC.
- Wait counter width: $clog2(max(T_RP, T_RFC, T_MRD_CYC)+1). Refresh counter width: 4 bits.
- Reset wins over everything in the same cycle. Abort wins over any state advance in the same cycle.

## Structure
- Package `sdram_pkg` holds:
  - The 4-bit command typedef and the five command constants.
  - The state enum.
  - A constant function for ns→cycle ceiling conversion.
- Single module, no sub-module. The wait counter and the refresh counter are inline.

## Test plan
- Reset held for 3 cycles, with `sdram_init_n` = 1 → cmd 1111, cke 0, done 0. A rising edge is ignored until a low sample is seen.
- `sdram_init_n` low for 20 cycles, then high at cycle E →
  - PRECHARGE with addr 13'h400 at E+1.
  - 8 AUTO REFRESH commands spaced exactly 8 cycles apart.
  - LOAD MODE with addr 13'h020 and ba 0 at E+68.
  - `init_done` = 1 at E+70.
- Between commands → only NOP (0111) on `sdram_cmd`, and cke stays 1 from HOLD onward.
- `sdram_init_n` driven low during the 4th refresh wait → HOLD next cycle, `init_busy` 0. After re-release, the full sequence repeats with exactly 8 refreshes.
- `reset` asserted in WAIT_MRD → next cycle all outputs at their reset values and `init_done` never pulses.
- Override REFRESH_COUNT = 2, T_RFC_NS = 100 (12 cycles) → `init_done` at P + 3 + 24 + 2 = P+29.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, init-sequencer state set and the
// ns-to-clock-cycle conversion used to size the JEDEC wait periods.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_INHIBIT   = 4'b1111;
  localparam sdram_cmd_t CMD_NOP       = 4'b0111;
  localparam sdram_cmd_t CMD_PRECHARGE = 4'b0010;
  localparam sdram_cmd_t CMD_REFRESH   = 4'b0001;
  localparam sdram_cmd_t CMD_LOAD_MODE = 4'b0000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOLD,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_REFRESH,
    ST_WAIT_RFC,
    ST_LOAD_MODE,
    ST_WAIT_MRD,
    ST_DONE
  } init_state_t;

  // Smallest whole number of clk_hz cycles covering ns nanoseconds.
  function automatic int ns_to_cycles(input int ns, input real clk_hz);
    real cyc;
    int  whole;
    cyc   = real'(ns) * clk_hz / 1.0e9;
    whole = int'($floor(cyc));
    if (real'(whole) < cyc) whole = whole + 1;
    return whole;
  endfunction

endpackage

// File: rtl/sdram_init_sequencer.sv
// JEDEC SDRAM power-up sequencer: PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE,
// then hands the bus over by raising init_done.
module sdram_init_sequencer
  import sdram_pkg::*;
#(
  parameter real                  CLK           = 111857000.0,
  parameter int                   T_RP_NS       = 20,
  parameter int                   T_RFC_NS      = 70,
  parameter int                   T_MRD_CYC     = 2,
  parameter int                   REFRESH_COUNT = 8,
  parameter int                   ADDR_BITS     = 13,
  parameter logic [ADDR_BITS-1:0] MODE_REG      = 13'h020
) (
  input  logic                 clk14M,
  input  logic                 reset,
  input  logic                 sdram_init_n,
  output logic                 sdram_cke,
  output logic [3:0]           sdram_cmd,
  output logic [ADDR_BITS-1:0] sdram_addr,
  output logic [1:0]           sdram_ba,
  output logic                 init_busy,
  output logic                 init_done
);

  localparam int T_RP     = ns_to_cycles(T_RP_NS, CLK);
  localparam int T_RFC    = ns_to_cycles(T_RFC_NS, CLK);
  localparam int T_MAX_AB = (T_RP > T_RFC) ? T_RP : T_RFC;
  localparam int WAIT_MAX = (T_MAX_AB > T_MRD_CYC) ? T_MAX_AB : T_MRD_CYC;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  localparam logic [ADDR_BITS-1:0] PRE_ALL_ADDR = ADDR_BITS'(1 << 10);
  localparam logic [WAIT_W-1:0]    WAIT_RP_LD   = WAIT_W'(T_RP - 1);
  localparam logic [WAIT_W-1:0]    WAIT_RFC_LD  = WAIT_W'(T_RFC - 1);
  localparam logic [WAIT_W-1:0]    WAIT_MRD_LD  = WAIT_W'(T_MRD_CYC - 1);
  localparam logic [WAIT_W-1:0]    WAIT_LAST    = WAIT_W'(1);
  localparam logic [3:0]           REF_TARGET   = 4'(REFRESH_COUNT);

  init_state_t       state;
  logic              init_n_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        ref_cnt;

  logic abort;
  assign abort = !sdram_init_n && (state != ST_IDLE) && (state != ST_HOLD);

  // Each branch sets the outputs for the state being entered, so every pin
  // is a flop and the command is on the bus for the whole state cycle.
  // NOTE: all state here is updated with <= so every register samples the
  // pre-edge values; a blocking assignment would leak new values downstream.
  always_ff @(posedge clk14M) begin
    if (reset) begin
      state      <= ST_IDLE;
      init_n_q   <= 1'b1;
      wait_cnt   <= '0;
      ref_cnt    <= '0;
      sdram_cke  <= 1'b0;
      sdram_cmd  <= CMD_INHIBIT;
      sdram_addr <= '0;
      sdram_ba   <= '0;
      init_busy  <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      init_n_q   <= sdram_init_n;
      sdram_cmd  <= CMD_NOP;
      sdram_addr <= '0;
      sdram_ba   <= '0;

      if (abort) begin
        state     <= ST_HOLD;
        sdram_cke <= 1'b1;
        wait_cnt  <= '0;
        ref_cnt   <= '0;
        init_busy <= 1'b0;
        init_done <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (!sdram_init_n) begin
              state     <= ST_HOLD;
              sdram_cke <= 1'b1;
            end else begin
              sdram_cmd <= CMD_INHIBIT;
            end
          end

          ST_HOLD: begin
            if (sdram_init_n && !init_n_q) begin
              state      <= ST_PRECHARGE;
              sdram_cmd  <= CMD_PRECHARGE;
              sdram_addr <= PRE_ALL_ADDR;
              init_busy  <= 1'b1;
            end
          end

          ST_PRECHARGE: begin
            state    <= ST_WAIT_RP;
            wait_cnt <= WAIT_RP_LD;
          end

          ST_WAIT_RP: begin
            if (wait_cnt == WAIT_LAST) begin
              state     <= ST_REFRESH;
              sdram_cmd <= CMD_REFRESH;
              wait_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end

          ST_REFRESH: begin
            state    <= ST_WAIT_RFC;
            ref_cnt  <= ref_cnt + 1'b1;
            wait_cnt <= WAIT_RFC_LD;
          end

          ST_WAIT_RFC: begin
            if (wait_cnt != WAIT_LAST) begin
              wait_cnt <= wait_cnt - 1'b1;
            end else if (ref_cnt < REF_TARGET) begin
              state     <= ST_REFRESH;
              sdram_cmd <= CMD_REFRESH;
              wait_cnt  <= '0;
            end else begin
              state      <= ST_LOAD_MODE;
              sdram_cmd  <= CMD_LOAD_MODE;
              sdram_addr <= MODE_REG;
              wait_cnt   <= '0;
            end
          end

          ST_LOAD_MODE: begin
            state    <= ST_WAIT_MRD;
            wait_cnt <= WAIT_MRD_LD;
          end

          ST_WAIT_MRD: begin
            if (wait_cnt == WAIT_LAST) begin
              state     <= ST_DONE;
              wait_cnt  <= '0;
              init_busy <= 1'b0;
              init_done <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end

          ST_DONE: begin
            state <= ST_DONE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Directed bench: default-parameter sequencer checked cycle by cycle against a
// command table, plus abort, reset-in-WAIT_MRD and a short-sequence variant.
module tb_sdram_init_sequencer;
  import sdram_pkg::*;

  logic        clk14M = 1'b0;
  logic        reset  = 1'b1;
  logic        sdram_init_n   = 1'b1;
  logic        sdram_init_n_s = 1'b1;

  logic        sdram_cke,  sdram_cke_s;
  logic [3:0]  sdram_cmd,  sdram_cmd_s;
  logic [12:0] sdram_addr, sdram_addr_s;
  logic [1:0]  sdram_ba,   sdram_ba_s;
  logic        init_busy,  init_busy_s;
  logic        init_done,  init_done_s;

  always #5 clk14M = ~clk14M;

  sdram_init_sequencer dut (
    .clk14M       (clk14M),
    .reset        (reset),
    .sdram_init_n (sdram_init_n),
    .sdram_cke    (sdram_cke),
    .sdram_cmd    (sdram_cmd),
    .sdram_addr   (sdram_addr),
    .sdram_ba     (sdram_ba),
    .init_busy    (init_busy),
    .init_done    (init_done)
  );

  sdram_init_sequencer #(
    .REFRESH_COUNT (2),
    .T_RFC_NS      (100)
  ) dut_s (
    .clk14M       (clk14M),
    .reset        (reset),
    .sdram_init_n (sdram_init_n_s),
    .sdram_cke    (sdram_cke_s),
    .sdram_cmd    (sdram_cmd_s),
    .sdram_addr   (sdram_addr_s),
    .sdram_ba     (sdram_ba_s),
    .init_busy    (init_busy_s),
    .init_done    (init_done_s)
  );

  typedef struct {
    int          offset;
    logic [3:0]  cmd;
    logic [12:0] addr;
  } vec_t;

  vec_t vecs[10];
  int   tests = 0;
  int   fails = 0;
  int   refs_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk14M);
    #1;
  endtask

  // Drives nothing; checks offsets 0..last after the release, offset 0 = PRECHARGE.
  task automatic run_seq(input int last, input string tag);
    logic [3:0]  ecmd;
    logic [12:0] eaddr;
    for (int k = 0; k <= last; k++) begin
      tick();
      ecmd  = CMD_NOP;
      eaddr = '0;
      foreach (vecs[i]) begin
        if (vecs[i].offset == k) begin
          ecmd  = vecs[i].cmd;
          eaddr = vecs[i].addr;
        end
      end
      if (sdram_cmd == CMD_REFRESH) refs_seen++;
      check($sformatf("%s k=%0d {cke,cmd,addr,ba,busy,done}", tag, k),
            32'({sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_busy, init_done}),
            32'({1'b1, ecmd, eaddr, 2'b00, (k < 69), (k >= 69)}));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ref_cnt_s;
    int first_ref_s;
    int lmr_off_s;
    int done_off_s;
    logic busy_at_done_s;

    vecs[0] = '{0,  CMD_PRECHARGE, 13'h400};
    vecs[1] = '{3,  CMD_REFRESH,   13'h000};
    vecs[2] = '{11, CMD_REFRESH,   13'h000};
    vecs[3] = '{19, CMD_REFRESH,   13'h000};
    vecs[4] = '{27, CMD_REFRESH,   13'h000};
    vecs[5] = '{35, CMD_REFRESH,   13'h000};
    vecs[6] = '{43, CMD_REFRESH,   13'h000};
    vecs[7] = '{51, CMD_REFRESH,   13'h000};
    vecs[8] = '{59, CMD_REFRESH,   13'h000};
    vecs[9] = '{67, CMD_LOAD_MODE, 13'h020};

    // Reset with init_n high.
    repeat (3) tick();
    check("reset cmd",  32'(sdram_cmd), 32'(4'b1111));
    check("reset cke",  32'(sdram_cke), 32'(1'b0));
    check("reset done", 32'(init_done), 32'(1'b0));
    check("reset busy", 32'(init_busy), 32'(1'b0));

    // High after reset is not an arming edge.
    reset = 1'b0;
    repeat (5) tick();
    check("idle ignores high cmd", 32'(sdram_cmd), 32'(CMD_INHIBIT));
    check("idle ignores high cke", 32'(sdram_cke), 32'(1'b0));
    check("idle ignores high busy", 32'(init_busy), 32'(1'b0));

    // Power-up hold for 20 cycles.
    sdram_init_n = 1'b0;
    tick();
    check("hold entry {cke,cmd}", 32'({sdram_cke, sdram_cmd}), 32'({1'b1, CMD_NOP}));
    repeat (19) tick();
    check("hold busy", 32'(init_busy), 32'(1'b0));

    sdram_init_n = 1'b1;
    refs_seen = 0;
    run_seq(72, "first");
    check("first refresh count", 32'(refs_seen), 32'(8));
    repeat (10) tick();
    check("done holds", 32'({init_done, init_busy, sdram_cmd}), 32'({1'b1, 1'b0, CMD_NOP}));

    // Abort from DONE, then rerun and abort in the 4th refresh wait.
    sdram_init_n = 1'b0;
    tick();
    check("abort from done", 32'({sdram_cke, sdram_cmd, init_busy, init_done}),
          32'({1'b1, CMD_NOP, 1'b0, 1'b0}));
    tick();
    sdram_init_n = 1'b1;
    refs_seen = 0;
    run_seq(30, "partial");
    check("refreshes before abort", 32'(refs_seen), 32'(4));
    sdram_init_n = 1'b0;
    tick();
    check("abort in wait_rfc", 32'({sdram_cke, sdram_cmd, sdram_addr, init_busy, init_done}),
          32'({1'b1, CMD_NOP, 13'h000, 1'b0, 1'b0}));
    repeat (2) tick();
    check("abort stays in hold", 32'({sdram_cmd, init_busy}), 32'({CMD_NOP, 1'b0}));
    sdram_init_n = 1'b1;
    refs_seen = 0;
    run_seq(72, "rerun");
    check("rerun refresh count", 32'(refs_seen), 32'(8));

    // Reset while in WAIT_MRD.
    sdram_init_n = 1'b0;
    repeat (2) tick();
    sdram_init_n = 1'b1;
    run_seq(68, "pre_reset");
    reset = 1'b1;
    tick();
    check("reset in wait_mrd", 32'({sdram_cke, sdram_cmd, sdram_addr, sdram_ba, init_busy, init_done}),
          32'({1'b0, 4'b1111, 13'h000, 2'b00, 1'b0, 1'b0}));
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("no done after reset i=%0d", i), 32'({init_done, sdram_cmd}),
            32'({1'b0, CMD_INHIBIT}));
    end

    // Short variant: 2 refreshes at T_RFC = 12 cycles.
    sdram_init_n_s = 1'b0;
    repeat (3) tick();
    sdram_init_n_s = 1'b1;
    ref_cnt_s      = 0;
    first_ref_s    = -1;
    lmr_off_s      = -1;
    done_off_s     = -1;
    busy_at_done_s = 1'b1;
    for (int k = 0; k < 60 && done_off_s < 0; k++) begin
      tick();
      if (k == 0) check("short precharge", 32'({sdram_cmd_s, sdram_addr_s}),
                        32'({CMD_PRECHARGE, 13'h400}));
      if (sdram_cmd_s == CMD_REFRESH) begin
        if (first_ref_s < 0) first_ref_s = k;
        ref_cnt_s++;
      end
      if (sdram_cmd_s == CMD_LOAD_MODE) lmr_off_s = k;
      if (init_done_s) begin
        done_off_s     = k;
        busy_at_done_s = init_busy_s;
      end
    end
    check("short refresh count", 32'(ref_cnt_s), 32'(2));
    check("short first refresh", 32'(first_ref_s), 32'(3));
    check("short load mode offset", 32'(lmr_off_s), 32'(27));
    check("short done offset", 32'(done_off_s), 32'(29));
    check("short busy at done", 32'(busy_at_done_s), 32'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
